// File: rtl/sram_like_bridge.sv
// Bridges the core's inst/data SRAM ports onto one req/addr_ok/data_ok bus.
// Data requests go first; one outstanding transaction; core held via core_stall.
module sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_wen,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_wdata,
    output logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              core_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);
    // state  | meaning
    // IDLE   | waiting for a core request
    // D_REQ  | data request on the bus, waiting for addr_ok
    // D_WAIT | data request accepted, waiting for data_ok
    // I_REQ  | inst request on the bus, waiting for addr_ok
    // I_WAIT | inst request accepted, waiting for data_ok
    // DONE   | one-cycle release of the core pipeline
    typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE} state_t;

    state_t            state;
    logic              pend_inst;
    logic              d_done;
    logic              i_done;
    logic [1:0]        d_size;
    logic [1:0]        d_off;
    logic [ADDR_W-1:0] inst_addr_al;
    logic              unused_inputs;

    assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0]};
    assign inst_addr_al  = {inst_sram_addr[ADDR_W-1:2], 2'b00};

    // Reads and unlisted strobe patterns fall back to an aligned word access.
    always_comb begin
        d_size = 2'd2;
        d_off  = 2'd0;
        case (data_sram_wen)
            4'b0001: begin d_size = 2'd0; d_off = 2'd0; end
            4'b0010: begin d_size = 2'd0; d_off = 2'd1; end
            4'b0100: begin d_size = 2'd0; d_off = 2'd2; end
            4'b1000: begin d_size = 2'd0; d_off = 2'd3; end
            4'b0011: begin d_size = 2'd1; d_off = 2'd0; end
            4'b1100: begin d_size = 2'd1; d_off = 2'd2; end
            default: ;
        endcase
    end

    assign d_done = data_ok && ((state == D_REQ && addr_ok) || state == D_WAIT);
    assign i_done = data_ok && ((state == I_REQ && addr_ok) || state == I_WAIT);

    assign core_stall = !rst && ((state == IDLE) ? (inst_sram_en || data_sram_en)
                                                 : (state != DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pend_inst       <= 1'b0;
            req             <= 1'b0;
            wr              <= 1'b0;
            size            <= 2'd0;
            addr            <= '0;
            wstrb           <= 4'd0;
            wdata           <= '0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pend_inst <= inst_sram_en;
                    if (data_sram_en) begin
                        req   <= 1'b1;
                        wr    <= |data_sram_wen;
                        size  <= d_size;
                        addr  <= {data_sram_addr[ADDR_W-1:2], d_off};
                        wstrb <= data_sram_wen;
                        wdata <= data_sram_wdata;
                        state <= D_REQ;
                    end else if (inst_sram_en) begin
                        req   <= 1'b1;
                        wr    <= 1'b0;
                        size  <= 2'd2;
                        addr  <= inst_addr_al;
                        wstrb <= 4'd0;
                        wdata <= '0;
                        state <= I_REQ;
                    end
                end
                D_REQ: if (addr_ok) begin
                    req   <= 1'b0;
                    state <= D_WAIT;
                end
                I_REQ: if (addr_ok) begin
                    req   <= 1'b0;
                    state <= I_WAIT;
                end
                D_WAIT, I_WAIT: ;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Completion overrides the REQ->WAIT move when both handshakes coincide.
            if (d_done) begin
                if (!wr) data_sram_rdata <= rdata;
                if (pend_inst) begin
                    req   <= 1'b1;
                    wr    <= 1'b0;
                    size  <= 2'd2;
                    addr  <= inst_addr_al;
                    wstrb <= 4'd0;
                    wdata <= '0;
                    state <= I_REQ;
                end else begin
                    state <= DONE;
                end
            end
            if (i_done) begin
                inst_sram_rdata <= rdata;
                state           <= DONE;
            end
        end
    end
endmodule
